afpm_stream_sequencer: RTL and testbench



---
 rtl/afpm_stream_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_afpm_stream_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afpm_stream_sequencer.sv
// afpm_stream_sequencer
//
// Streaming front end for the byte-serial logarithmic FP16 multiplier.
// It accepts one FP16 operand pair per valid/ready handshake and wakes the
// multiplier with a start token. It then sends the operand bytes low byte
// first, waits a fixed latency, and captures the two result bytes. The
// 16-bit product is presented on a valid/ready output.
//
// Ports
//   clk, rst_n          clock and async active-low reset (shared with multiplier)
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   in_a, in_b          FP16 operands
//   mul_ui, mul_uio     to multiplier ui_in / uio_in (token + A bytes / B bytes)
//   mul_uo              from multiplier uo_out
//   out_valid/out_ready product handshake
//   out_result          FP16 product
//   busy                high in every state except IDLE
//   op_count            completed output handshakes, wraps modulo 256
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for an operand pair, multiplier inputs held at 0
// START   | start token on mul_ui
// SEND_LO | low bytes of A/B on mul_ui/mul_uio
// SEND_HI | high bytes of A/B, wait counter loaded
// WAIT    | counting down the multiplier latency
// CAP_LO  | mul_uo is the low result byte, sampled at end of cycle
// CAP_HI  | mul_uo is the high result byte, sampled at end of cycle
// DONE    | product valid, held until out_ready

module afpm_stream_sequencer #(
  parameter int unsigned WAIT_CYCLES = 7,
  parameter logic [7:0]  START_TOKEN = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [7:0]  mul_ui,
  output logic [7:0]  mul_uio,
  input  logic [7:0]  mul_uo,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        busy,
  output logic [7:0]  op_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND_LO,
    S_SEND_HI,
    S_WAIT,
    S_CAP_LO,
    S_CAP_HI,
    S_DONE
  } state_t;

  // The counter is loaded with WAIT_CYCLES-1 so that the state stays in
  // WAIT for exactly WAIT_CYCLES cycles, including the cycle that sees zero.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [3:0]  wait_q, wait_d;
  logic [7:0]  mul_ui_q, mul_ui_d;
  logic [7:0]  mul_uio_q, mul_uio_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_result_q, out_result_d;
  logic [7:0]  op_count_q, op_count_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    wait_d       = wait_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    op_count_d   = op_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = S_START;
        end
      end
      S_START:   state_d = S_SEND_LO;
      S_SEND_LO: state_d = S_SEND_HI;
      S_SEND_HI: begin
        wait_d  = WAIT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == 4'd0) begin
          state_d = S_CAP_LO;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_CAP_LO: begin
        out_result_d[7:0] = mul_uo;
        state_d           = S_CAP_HI;
      end
      S_CAP_HI: begin
        out_result_d[15:8] = mul_uo;
        out_valid_d        = 1'b1;
        state_d            = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The multiplier wakes on any nonzero ui_in, so its inputs are driven
    // only in the three send states. They are decoded from the next state
    // so that the registered value lines up with the state it belongs to.
    mul_ui_d  = 8'h00;
    mul_uio_d = 8'h00;
    unique case (state_d)
      S_START: mul_ui_d = START_TOKEN;
      S_SEND_LO: begin
        mul_ui_d  = a_q[7:0];
        mul_uio_d = b_q[7:0];
      end
      S_SEND_HI: begin
        mul_ui_d  = a_q[15:8];
        mul_uio_d = b_q[15:8];
      end
      default: begin
        mul_ui_d  = 8'h00;
        mul_uio_d = 8'h00;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= 16'h0000;
      b_q          <= 16'h0000;
      wait_q       <= 4'd0;
      mul_ui_q     <= 8'h00;
      mul_uio_q    <= 8'h00;
      out_valid_q  <= 1'b0;
      out_result_q <= 16'h0000;
      op_count_q   <= 8'h00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      wait_q       <= wait_d;
      mul_ui_q     <= mul_ui_d;
      mul_uio_q    <= mul_uio_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      op_count_q   <= op_count_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign mul_ui     = mul_ui_q;
  assign mul_uio    = mul_uio_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign op_count   = op_count_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_afpm_stream_sequencer.sv
// Directed bench for afpm_stream_sequencer. A small multiplier stand-in
// tracks the start token and presents the expected product bytes on mul_uo
// only in the two capture cycles (k+10, k+11). It drives 8'hA5 otherwise.
module tb_afpm_stream_sequencer;

  localparam logic [7:0] TOK = 8'h01;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'h0000;
  logic [15:0] in_b = 16'h0000;
  logic [7:0]  mul_ui;
  logic [7:0]  mul_uio;
  logic [7:0]  mul_uo = 8'hA5;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic        busy;
  logic [7:0]  op_count;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_prod = 16'h0000;
  logic [7:0]  exp_cnt = 8'h00;

  afpm_stream_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_ui     (mul_ui),
    .mul_uio    (mul_uio),
    .mul_uo     (mul_uo),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy),
    .op_count   (op_count)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Multiplier stand-in: rel counts cycles since the token cycle k.
  int         rel = 99;
  logic [7:0] prev_ui = 8'h00;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      rel     = 99;
      prev_ui = 8'h00;
    end else begin
      if (mul_ui == TOK && prev_ui == 8'h00) rel = 0;
      else if (rel < 99) rel = rel + 1;
      prev_ui = mul_ui;
    end
    mul_uo = (rel == 10) ? exp_prod[7:0] : (rel == 11) ? exp_prod[15:8] : 8'hA5;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits for in_ready, presents the pair, and returns at the first negedge
  // after the accept edge (the token cycle k).
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] p);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL start_op_timeout: in_ready=%0b required 1", in_ready);
    end
    exp_prod = p;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    checks++;
    if ({mul_ui, mul_uio, out_valid, out_result, op_count, in_ready, busy} !== {8'h00, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_async: ui=%h uio=%h ov=%b res=%h cnt=%h ir=%b busy=%b required 00 00 0 0000 00 1 0",
               mul_ui, mul_uio, out_valid, out_result, op_count, in_ready, busy);
    end
    #5 rst_n = 1'b1;
    clk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mul_ui !== 8'h00 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle_ui: cycle %0d mul_ui=%h busy=%b required 00 0", i, mul_ui, busy);
      end
    end
  endtask

  task automatic test_one();
    int lat;
    start_op(16'h3C00, 16'h3C00, 16'h3C00);
    checks++;
    if ({mul_ui, mul_uio} !== 16'h0100) begin
      failures++; $display("FAIL seq_k0: ui/uio=%h required 0100", {mul_ui, mul_uio});
    end
    @(negedge clk);
    checks++;
    if ({mul_ui, mul_uio} !== 16'h0000) begin
      failures++; $display("FAIL seq_k1: ui/uio=%h required 0000", {mul_ui, mul_uio});
    end
    @(negedge clk);
    checks++;
    if ({mul_ui, mul_uio} !== 16'h3C3C) begin
      failures++; $display("FAIL seq_k2: ui/uio=%h required 3C3C", {mul_ui, mul_uio});
    end
    @(negedge clk);
    checks++;
    if ({mul_ui, mul_uio, busy, in_ready} !== {16'h0000, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL seq_k3: ui/uio=%h busy=%b ir=%b required 0000 1 0", {mul_ui, mul_uio}, busy, in_ready);
    end
    wait_result(lat);
    lat = lat + 3;
    checks++;
    if (lat !== 12) begin
      failures++; $display("FAIL one_latency: got %0d required 12", lat);
    end
    checks++;
    if (out_result !== 16'h3C00) begin
      failures++; $display("FAIL one_result: got %h required 3C00", out_result);
    end
    finish_op();
    checks++;
    if (op_count !== exp_cnt || out_valid !== 1'b0) begin
      failures++; $display("FAIL one_count: cnt=%h ov=%b required %h 0", op_count, out_valid, exp_cnt);
    end
  endtask

  task automatic test_sign();
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (op_count !== exp_cnt || out_valid !== 1'b0) begin
      failures++; $display("FAIL stray_ready: cnt=%h ov=%b required %h 0", op_count, out_valid, exp_cnt);
    end
    start_op(16'hBC00, 16'h3C00, 16'hBC00);
    wait_result(lat);
    checks++;
    if (lat !== 12 || out_result !== 16'hBC00) begin
      failures++; $display("FAIL sign_result: lat=%0d res=%h required 12 BC00", lat, out_result);
    end
    finish_op();
    checks++;
    if (op_count !== exp_cnt) begin
      failures++; $display("FAIL sign_count: got %h required %h", op_count, exp_cnt);
    end
  endtask

  task automatic test_approx();
    int lat;
    start_op(16'h4000, 16'h4200, 16'h46A3);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({mul_ui, mul_uio} !== 16'h4042) begin
      failures++; $display("FAIL approx_hi_bytes: ui/uio=%h required 4042", {mul_ui, mul_uio});
    end
    wait_result(lat);
    lat = lat + 2;
    checks++;
    if (lat !== 12 || out_result !== 16'h46A3) begin
      failures++; $display("FAIL approx_result: lat=%0d res=%h required 12 46A3", lat, out_result);
    end
    finish_op();
    checks++;
    if (op_count !== exp_cnt) begin
      failures++; $display("FAIL approx_count: got %h required %h", op_count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    start_op(16'h3C00, 16'h3C00, 16'h3C00);
    wait_result(lat);
    checks++;
    if (lat !== 12 || out_result !== 16'h3C00) begin
      failures++; $display("FAIL b2b_first: lat=%0d res=%h required 12 3C00", lat, out_result);
    end
    // Second op queued while the first result is back-pressured.
    in_a = 16'h4000;
    in_b = 16'h4200;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b1 || out_result !== 16'h3C00 || in_ready !== 1'b0 ||
          mul_ui !== 8'h00 || mul_uio !== 8'h00) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL backpressure_hold: %0d bad cycles required 0", bad);
    end
    exp_prod = 16'h46A3;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    checks++;
    if ({out_valid, in_ready, mul_ui} !== {1'b0, 1'b1, 8'h00} || op_count !== exp_cnt) begin
      failures++;
      $display("FAIL b2b_handshake: ov=%b ir=%b ui=%h cnt=%h required 0 1 00 %h",
               out_valid, in_ready, mul_ui, op_count, exp_cnt);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (mul_ui !== TOK) begin
      failures++; $display("FAIL b2b_start: ui=%h required 01", mul_ui);
    end
    wait_result(lat);
    checks++;
    if (lat !== 12 || out_result !== 16'h46A3) begin
      failures++; $display("FAIL b2b_second: lat=%0d res=%h required 12 46A3", lat, out_result);
    end
    finish_op();
    checks++;
    if (op_count !== exp_cnt) begin
      failures++; $display("FAIL b2b_count: got %h required %h", op_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int bad;
    start_op(16'h3C00, 16'h3C00, 16'h1234);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_cnt = 8'h00;
    checks++;
    if ({mul_ui, busy, in_ready, out_valid, op_count} !== {8'h00, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_mid: ui=%h busy=%b ir=%b ov=%b cnt=%h required 00 0 1 0 00",
               mul_ui, busy, in_ready, out_valid, op_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || mul_ui !== 8'h00) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL reset_mid_quiet: %0d bad cycles required 0", bad);
    end
    start_op(16'h3C00, 16'h3C00, 16'h3C00);
    wait_result(lat);
    checks++;
    if (lat !== 12 || out_result !== 16'h3C00) begin
      failures++; $display("FAIL reset_mid_next: lat=%0d res=%h required 12 3C00", lat, out_result);
    end
    finish_op();
    checks++;
    if (op_count !== 8'h01) begin
      failures++; $display("FAIL reset_mid_count: got %h required 01", op_count);
    end
  endtask

  task automatic test_wrap();
    int lat;
    int bad;
    logic [15:0] p;
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      p = 16'(i * 16'h0101 + 16'h0102);
      start_op(16'(i), 16'(i << 3), p);
      wait_result(lat);
      if (lat !== 12 || out_result !== p) bad++;
      finish_op();
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL wrap_results: %0d bad ops required 0", bad);
    end
    checks++;
    if (op_count !== 8'h00 || exp_cnt !== 8'h00) begin
      failures++; $display("FAIL wrap_count: got %h required 00", op_count);
    end
  endtask

  initial begin
    test_reset();
    test_one();
    test_sign();
    test_approx();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
